// File: rtl/servo_pulse_decoder.sv
// Servo pulse decoder: measures the high time of a 50 Hz servo pulse in clk ticks.
// Optional input glitch filter enabled with `define SERVO_GLITCH_FILTER_EN.
module servo_pulse_decoder #(
   parameter int PW_MIN  = 6000,
   parameter int PW_MAX  = 30000,
   parameter int TIMEOUT = 600000,
   parameter int GF_LEN  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        servo_in,
   output logic [17:0] pos,
   output logic        pos_stb,
   output logic        err_stb,
   output logic        lost
);

   localparam int W_W    = 18;
   localparam int T_W    = 20;
   localparam int SYNC_N = 2;

   localparam logic [W_W-1:0] W_SAT    = '1;
   localparam logic [W_W-1:0] PW_MIN_W = W_W'(PW_MIN);
   localparam logic [W_W-1:0] PW_MAX_W = W_W'(PW_MAX);
   localparam logic [T_W-1:0] T_SAT    = '1;
   localparam logic [T_W-1:0] TO_LAST  = T_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_ARM,
      ST_WAIT,
      ST_HIGH
   } state_t;

   // Synchroniser is deliberately not reset so it tracks the pin during reset.
   logic [SYNC_N-1:0] sync_reg;
   logic              s_sync;
   logic              s;
   logic              s_dly_reg;

   genvar gi;
   generate
      for (gi = 0; gi < SYNC_N; gi++) begin : g_sync
         if (gi == 0) begin : g_first
            always_ff @(posedge clk) begin
               sync_reg[gi] <= servo_in;
            end
         end else begin : g_next
            always_ff @(posedge clk) begin
               sync_reg[gi] <= sync_reg[gi-1];
            end
         end
      end

      // Named marker only; a filter length below one is not meaningful.
      if (GF_LEN < 1) begin : g_gf_len_invalid
      end
   endgenerate

   assign s_sync = sync_reg[SYNC_N-1];

`ifdef SERVO_GLITCH_FILTER_EN
   localparam int GF_W = $clog2(GF_LEN + 1);

   logic            s_filt_reg;
   logic [GF_W-1:0] gf_cnt_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         s_filt_reg <= s_sync;
         gf_cnt_reg <= '0;
      end else if (s_sync == s_filt_reg) begin
         gf_cnt_reg <= '0;
      end else if (gf_cnt_reg == GF_W'(GF_LEN - 1)) begin
         s_filt_reg <= s_sync;
         gf_cnt_reg <= '0;
      end else begin
         gf_cnt_reg <= gf_cnt_reg + 1'b1;
      end
   end

   assign s = s_filt_reg;
`else
   assign s = s_sync;
`endif

   // Loaded from s even in reset so no false edge appears at reset release.
   always_ff @(posedge clk) begin
      s_dly_reg <= s;
   end

   logic rise;
   logic fall;
   assign rise = s & ~s_dly_reg;
   assign fall = ~s & s_dly_reg;

   state_t         state_reg;
   logic [W_W-1:0] width_reg;
   logic [T_W-1:0] to_cnt_reg;
   logic [T_W-1:0] to_cnt_next;
   logic           timeout_hit;
   logic           eval_reg;
   logic [W_W-1:0] pos_reg;
   logic           pos_stb_reg;
   logic           err_stb_reg;
   logic           lost_reg;

   always_comb begin
      to_cnt_next = to_cnt_reg;
      if (rise) begin
         to_cnt_next = '0;
      end else if (to_cnt_reg != T_SAT) begin
         to_cnt_next = to_cnt_reg + 1'b1;
      end
   end

   // Fires once, on the cycle the counter steps onto TIMEOUT.
   assign timeout_hit = ~rise && (to_cnt_reg == TO_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= ST_ARM;
         width_reg   <= '0;
         to_cnt_reg  <= '0;
         eval_reg    <= 1'b0;
         pos_reg     <= '0;
         pos_stb_reg <= 1'b0;
         err_stb_reg <= 1'b0;
         lost_reg    <= 1'b1;
      end else begin
         pos_stb_reg <= 1'b0;
         err_stb_reg <= 1'b0;
         eval_reg    <= 1'b0;
         to_cnt_reg  <= to_cnt_next;

         if (eval_reg) begin
            if (width_reg >= PW_MIN_W && width_reg <= PW_MAX_W) begin
               pos_reg     <= width_reg;
               pos_stb_reg <= 1'b1;
               lost_reg    <= 1'b0;
            end else begin
               err_stb_reg <= 1'b1;
            end
         end

         if (timeout_hit) begin
            state_reg <= ST_ARM;
            lost_reg  <= 1'b1;
         end else begin
            case (state_reg)
               ST_ARM: begin
                  if (!s) state_reg <= ST_WAIT;
               end
               ST_WAIT: begin
                  if (rise) begin
                     state_reg <= ST_HIGH;
                     width_reg <= W_W'(1);
                  end
               end
               ST_HIGH: begin
                  if (fall) begin
                     state_reg <= ST_WAIT;
                     eval_reg  <= 1'b1;
                  end else if (width_reg != W_SAT) begin
                     width_reg <= width_reg + 1'b1;
                  end
               end
               default: state_reg <= ST_ARM;
            endcase
         end
      end
   end

   assign pos     = pos_reg;
   assign pos_stb = pos_stb_reg;
   assign err_stb = err_stb_reg;
   assign lost    = lost_reg;

endmodule
